gf2_min_weight_solve: RTL and testbench
=======================================

// Module: gf2_min_weight_solve
// PURPOSE
//  Downstream consumer of gf2_rref. Takes a GF(2) augmented matrix in reduced row-echelon form.
//  Enumerates every assignment of the free variables and back-substitutes the pivot variables.
//  Returns the minimum-Hamming-weight solution vector and its weight (fewest button presses).
//  Flags the system unsolvable when the RREF contains a 0 = 1 row.
// PARAMETERS
//  ROWS  2  rows of the augmented matrix (equations)
//  COLS  3  columns incl. augmented column; VARS = COLS-1 unknowns, WW = $clog2(VARS+1)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        async active-low reset
//  start      in   1        pulse: latch RREF and begin solving
//  RREF       in   [COLS-1:0] x ROWS (unpacked [ROWS-1:0])  matrix from gf2_rref
//  ready      out  1        result valid; held until next accepted start
//  solvable   out  1        1 = consistent system; valid while ready
//  min_weight out  WW       popcount of SOLN; 0 when !solvable
//  SOLN       out  VARS     min-weight solution, bit k = variable k; 0 when !solvable
//  n_min      out  VARS+1   only with GF2_SOLVE_COUNT_EN, see CONFIGURATION
// BEHAVIOUR
//  Column map: bit 0 = RHS; bit k+1 = coefficient of variable k.
//  Reset (async, rst_n=0): state IDLE; ready=0, solvable=0, min_weight=0, SOLN=0, internal regs 0.
//  FSM IDLE -> SCAN -> ENUM -> DONE.
//  IDLE / DONE:
//   - start=1 latches RREF, clears ready, goes to SCAN.
//   - start is ignored in SCAN and ENUM (no restart, no error).
//  SCAN: one row per cycle, r = 0..ROWS-1.
//   - pivot(r) = lowest-index nonzero coefficient bit; sets bit in pivot_mask.
//   - A row with zero coefficients and RHS=0 is ignored.
//   - A row with zero coefficients and RHS=1 sets inconsistent.
//   - After row ROWS-1: inconsistent -> DONE with solvable=0.
//   - Otherwise free_mask = ~pivot_mask, NF = popcount(free_mask), counter=0, best_w = all-ones, -> ENUM.
//  ENUM: one assignment per cycle.
//   - free vars = counter bits deposited in ascending order onto free_mask positions.
//   - pivot var of row r = RHS_r XOR parity(coef_r & free assignment).
//   - w = popcount(x). If w < best_w (strict), store x and w; ties keep the earlier (lower) counter.
//   - Leave ENUM when counter == 2^NF - 1 (NF=0: exactly one cycle).
//  DONE: ready=1, solvable=1, outputs registered.
//  Latency, counted in edges from the edge sampling start to ready=1:
//   - solvable case: ROWS + 2^NF + 1
//   - unsolvable case: ROWS + 1
//  Mid-operation rst_n assertion aborts immediately to the reset values.
//  Counter width is VARS+1 so 2^VARS does not wrap.
// CONFIGURATION
//  GF2_SOLVE_COUNT_EN defined:
//   - adds port n_min = number of assignments achieving min_weight.
//   - reset to 1 on each strict improvement, +1 on each tie.
//   - 0 when !solvable; reset value 0.
//  Undefined: no n_min port, no tie counter logic.
// STRUCTURE
//  gf2_pkg holds:
//   - state_t enum {IDLE, SCAN, ENUM, DONE}
//   - functions popcount(), parity(), deposit() (pdep onto a mask)
//   - localparam AUG_COL = 0
//  One sub-module: gf2_popcount, a parameterised combinational weight tree used in ENUM.
// TESTING (both ROWS/COLS configs 2x3 and 3x4, like gf2_rref_tb)
//  1. 2x3, RREF={3'b011,3'b101}
//     -> solvable=1, SOLN=2'b11, min_weight=2, ready 4 edges after start (NF=0).
//  2. 2x3, RREF={3'b001,3'b000}
//     -> solvable=0, SOLN=0, min_weight=0, ready after 3 edges.
//  3. 3x4, RREF={4'b1011,4'b1101,4'b0000}
//     -> NF=1, SOLN=3'b100, min_weight=1, ready after 6 edges.
//  4. 3x4, all-zero RREF
//     -> NF=3, SOLN=0, min_weight=0, ready after 12 edges; n_min=1 when COUNT_EN.
//  5. 2x3, RREF={3'b111,3'b000}
//     -> tie: SOLN=2'b01, min_weight=1; n_min=2 when COUNT_EN.
//  6. Start during ENUM is ignored.
//     rst_n low mid-ENUM -> all outputs 0 at once.
//     Start in DONE: ready drops next edge, new result correct.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared types and bit helpers for the GF(2) minimum-weight solver.
// Helpers work on a fixed 32-bit container; callers zero-extend narrower vectors.
package gf2_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, ENUM, DONE} state_t;

    localparam int AUG_COL = 0;
    localparam int MAXW    = 32;

    function automatic logic [5:0] popcount(input logic [MAXW-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAXW; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    function automatic logic parity(input logic [MAXW-1:0] v);
        return ^v;
    endfunction

    // Parallel bit deposit: low bits of src scattered onto the set bits of mask, ascending.
    function automatic logic [MAXW-1:0] deposit(input logic [MAXW-1:0] src,
                                                 input logic [MAXW-1:0] mask);
        logic [MAXW-1:0] res;
        logic [5:0]      j;
        res = '0;
        j   = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (mask[i]) begin
                res[i] = src[j[4:0]];
                j      = j + 6'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gf2_popcount.sv
// Combinational Hamming-weight counter for a W-bit vector.
module gf2_popcount #(
    parameter int W = 2,
    localparam int CNTW = $clog2(W + 1)
) (
    input  logic [W-1:0]    bits,
    output logic [CNTW-1:0] count
);

    logic [CNTW-1:0] partial [W+1];

    assign partial[0] = '0;

    for (genvar gi = 0; gi < W; gi++) begin : g_acc
        assign partial[gi+1] = partial[gi] + CNTW'(bits[gi]);
    end

    assign count = partial[W];

endmodule

// File: rtl/gf2_min_weight_solve.sv
// Minimum-weight solution search over an RREF GF(2) system (scan rows, enumerate free vars).
// Optional tie counter output n_min is enabled by defining GF2_SOLVE_COUNT_EN.
module gf2_min_weight_solve
    import gf2_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [COLS-1:0]           RREF [ROWS-1:0],
    output logic                      ready,
    output logic                      solvable,
    output logic [$clog2(COLS)-1:0]   min_weight,
    output logic [COLS-2:0]           SOLN
`ifdef GF2_SOLVE_COUNT_EN
    ,
    output logic [COLS-1:0]           n_min
`endif
);

    localparam int VARS = COLS - 1;
    localparam int WW   = $clog2(COLS);
    localparam int CW   = VARS + 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t          state;
    logic [COLS-1:0] rref_reg [ROWS-1:0];
    logic [VARS-1:0] piv_oh   [ROWS-1:0];
    logic [VARS-1:0] pivot_mask;
    logic [VARS-1:0] free_mask;
    logic            inconsistent;
    logic [RW-1:0]   row_idx;
    logic [CW-1:0]   counter;
    logic [CW-1:0]   last_cnt;
    logic [VARS-1:0] best_x;
    logic [WW:0]     best_w;

    // Scan-stage view of the current row
    logic [COLS-1:0] scan_row;
    logic [VARS-1:0] scan_coef, scan_piv, pivot_next, free_next;
    logic            incons_next;
    logic [5:0]      nf_next;
    logic [CW-1:0]   last_next;

    always_comb begin
        scan_row    = rref_reg[row_idx];
        scan_coef   = scan_row[COLS-1:1];
        scan_piv    = scan_coef & (~scan_coef + VARS'(1));
        pivot_next  = pivot_mask | scan_piv;
        free_next   = ~pivot_next;
        incons_next = inconsistent | ((scan_coef == '0) & scan_row[AUG_COL]);
        nf_next     = popcount(32'(free_next));
        last_next   = CW'((32'd1 << nf_next) - 32'd1);
    end

    // Enumeration stage: free variables from the counter, pivots back-substituted
    logic [VARS-1:0] free_assign, x_cand, bx_next;
    logic [VARS-1:0] row_fix [ROWS-1:0];
    logic [WW-1:0]   x_w;
    logic [WW:0]     bw_next;
    logic            improve, tie;

    assign free_assign = VARS'(deposit(32'(counter), 32'(free_mask)));

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_fix[gi] = (rref_reg[gi][AUG_COL] ^
                              parity(32'(rref_reg[gi][COLS-1:1] & free_assign))) ? piv_oh[gi] : '0;
    end

    always_comb begin
        x_cand = free_assign;
        for (int r = 0; r < ROWS; r++) begin
            x_cand = x_cand | row_fix[r];
        end
    end

    gf2_popcount #(.W(VARS)) u_popcount (
        .bits  (x_cand),
        .count (x_w)
    );

    assign improve = {1'b0, x_w} < best_w;
    assign tie     = {1'b0, x_w} == best_w;
    assign bx_next = improve ? x_cand : best_x;
    assign bw_next = improve ? {1'b0, x_w} : best_w;

`ifdef GF2_SOLVE_COUNT_EN
    logic [CW-1:0] best_n, bn_next;
    assign bn_next = improve ? CW'(1) : (tie ? best_n + CW'(1) : best_n);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready        <= 1'b0;
            solvable     <= 1'b0;
            min_weight   <= '0;
            SOLN         <= '0;
            pivot_mask   <= '0;
            free_mask    <= '0;
            inconsistent <= 1'b0;
            row_idx      <= '0;
            counter      <= '0;
            last_cnt     <= '0;
            best_x       <= '0;
            best_w       <= '0;
            for (int r = 0; r < ROWS; r++) begin
                rref_reg[r] <= '0;
                piv_oh[r]   <= '0;
            end
`ifdef GF2_SOLVE_COUNT_EN
            n_min        <= '0;
            best_n       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rref_reg     <= RREF;
                        ready        <= 1'b0;
                        row_idx      <= '0;
                        pivot_mask   <= '0;
                        inconsistent <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    piv_oh[row_idx] <= scan_piv;
                    pivot_mask      <= pivot_next;
                    inconsistent    <= incons_next;
                    if (row_idx == RW'(ROWS - 1)) begin
                        if (incons_next) begin
                            solvable   <= 1'b0;
                            SOLN       <= '0;
                            min_weight <= '0;
`ifdef GF2_SOLVE_COUNT_EN
                            n_min      <= '0;
`endif
                            ready      <= 1'b1;
                            state      <= DONE;
                        end else begin
                            free_mask <= free_next;
                            last_cnt  <= last_next;
                            counter   <= '0;
                            best_w    <= '1;
                            best_x    <= '0;
`ifdef GF2_SOLVE_COUNT_EN
                            best_n    <= '0;
`endif
                            state     <= ENUM;
                        end
                    end else begin
                        row_idx <= row_idx + RW'(1);
                    end
                end
                ENUM: begin
                    best_x  <= bx_next;
                    best_w  <= bw_next;
                    counter <= counter + CW'(1);
`ifdef GF2_SOLVE_COUNT_EN
                    best_n  <= bn_next;
`endif
                    if (counter == last_cnt) begin
                        SOLN       <= bx_next;
                        min_weight <= WW'(bw_next);
                        solvable   <= 1'b1;
                        ready      <= 1'b1;
`ifdef GF2_SOLVE_COUNT_EN
                        n_min      <= bn_next;
`endif
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_min_weight_solve.sv
// Directed bench for gf2_min_weight_solve in 2x3 and 3x4 configurations.
module tb_gf2_min_weight_solve;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start2;
    logic [2:0] rref2 [1:0];
    logic       ready2, solvable2;
    logic [1:0] mw2;
    logic [1:0] soln2;
    logic [2:0] n_min2;

    logic       start3;
    logic [3:0] rref3 [2:0];
    logic       ready3, solvable3;
    logic [1:0] mw3;
    logic [2:0] soln3;
    logic [3:0] n_min3;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    gf2_min_weight_solve #(.ROWS(2), .COLS(3)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .RREF       (rref2),
        .ready      (ready2),
        .solvable   (solvable2),
        .min_weight (mw2),
        .SOLN       (soln2)
`ifdef GF2_SOLVE_COUNT_EN
        ,
        .n_min      (n_min2)
`endif
    );

    gf2_min_weight_solve #(.ROWS(3), .COLS(4)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .RREF       (rref3),
        .ready      (ready3),
        .solvable   (solvable3),
        .min_weight (mw3),
        .SOLN       (soln3)
`ifdef GF2_SOLVE_COUNT_EN
        ,
        .n_min      (n_min3)
`endif
    );

`ifndef GF2_SOLVE_COUNT_EN
    assign n_min2 = '0;
    assign n_min3 = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run2(input logic [2:0] r1, input logic [2:0] r0);
        @(negedge clk);
        rref2[1] = r1;
        rref2[0] = r0;
        start2   = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat    = 1;
        chk("ready_drop2", 32'(ready2), 32'd0);
        while (ready2 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run3(input logic [3:0] r2, input logic [3:0] r1, input logic [3:0] r0);
        @(negedge clk);
        rref3[2] = r2;
        rref3[1] = r1;
        rref3[0] = r0;
        start3   = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat    = 1;
        chk("ready_drop3", 32'(ready3), 32'd0);
        while (ready3 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic res2(input string tag, input int elat, input logic es,
                        input logic [1:0] ex, input logic [1:0] ew, input logic [2:0] en);
        $display("txn %s lat=%0d solvable=%0b soln=%0h min_weight=%0d (exp n_min=%0d)",
                 tag, lat, solvable2, soln2, mw2, en);
        chk({tag, "_lat"},      32'(lat),       32'(elat));
        chk({tag, "_solvable"}, 32'(solvable2), 32'(es));
        chk({tag, "_soln"},     32'(soln2),     32'(ex));
        chk({tag, "_weight"},   32'(mw2),       32'(ew));
`ifdef GF2_SOLVE_COUNT_EN
        chk({tag, "_n_min"},    32'(n_min2),    32'(en));
`endif
    endtask

    task automatic res3(input string tag, input int elat, input logic es,
                        input logic [2:0] ex, input logic [1:0] ew, input logic [3:0] en);
        $display("txn %s lat=%0d solvable=%0b soln=%0h min_weight=%0d (exp n_min=%0d)",
                 tag, lat, solvable3, soln3, mw3, en);
        chk({tag, "_lat"},      32'(lat),       32'(elat));
        chk({tag, "_solvable"}, 32'(solvable3), 32'(es));
        chk({tag, "_soln"},     32'(soln3),     32'(ex));
        chk({tag, "_weight"},   32'(mw3),       32'(ew));
`ifdef GF2_SOLVE_COUNT_EN
        chk({tag, "_n_min"},    32'(n_min3),    32'(en));
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        start2   = 1'b0;
        start3   = 1'b0;
        rref2[1] = '0; rref2[0] = '0;
        rref3[2] = '0; rref3[1] = '0; rref3[0] = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("txn reset ready2=%0b ready3=%0b", ready2, ready3);
        chk("rst_ready2",    32'(ready2),    32'd0);
        chk("rst_solvable2", 32'(solvable2), 32'd0);
        chk("rst_soln2",     32'(soln2),     32'd0);
        chk("rst_weight2",   32'(mw2),       32'd0);
        chk("rst_ready3",    32'(ready3),    32'd0);
        chk("rst_soln3",     32'(soln3),     32'd0);
        chk("rst_nmin3",     32'(n_min3),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2x3 configuration
        run2(3'b011, 3'b101); res2("t1_unique",  4, 1'b1, 2'b11, 2'd2, 3'd1);
        run2(3'b001, 3'b000); res2("t2_incons",  3, 1'b0, 2'b00, 2'd0, 3'd0);
        run2(3'b111, 3'b000); res2("t5_tie",     5, 1'b1, 2'b01, 2'd1, 3'd2);

        // 3x4 configuration
        run3(4'b1011, 4'b1101, 4'b0000); res3("t3_nf1",    6,  1'b1, 3'b100, 2'd1, 4'd1);
        run3(4'b0000, 4'b0000, 4'b0000); res3("t4_nf3",    12, 1'b1, 3'b000, 2'd0, 4'd1);
        run3(4'b0001, 4'b0000, 4'b0011); res3("t7_incons", 4,  1'b0, 3'b000, 2'd0, 4'd0);

        // start pulse during ENUM must be ignored
        @(negedge clk);
        rref3[2] = '0; rref3[1] = '0; rref3[0] = '0;
        start3   = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat    = 1;
        repeat (5) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        rref3[0] = 4'b0001;
        start3   = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat++;
        while (ready3 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res3("t6_start_in_enum", 12, 1'b1, 3'b000, 2'd0, 4'd1);

        // all variables pivoted to 1: maximum weight result
        run3(4'b1001, 4'b0101, 4'b0011); res3("t8_weight3", 5, 1'b1, 3'b111, 2'd3, 4'd1);

        // reset asserted in the middle of ENUM
        @(negedge clk);
        rref3[2] = '0; rref3[1] = '0; rref3[0] = '0;
        start3   = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn midreset ready3=%0b solvable3=%0b soln3=%0h mw3=%0d", ready3, solvable3, soln3, mw3);
        chk("mrst_ready3",    32'(ready3),    32'd0);
        chk("mrst_solvable3", 32'(solvable3), 32'd0);
        chk("mrst_soln3",     32'(soln3),     32'd0);
        chk("mrst_weight3",   32'(mw3),       32'd0);
        chk("mrst_ready2",    32'(ready2),    32'd0);
        chk("mrst_soln2",     32'(soln2),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run3(4'b1011, 4'b1101, 4'b0000); res3("t9_recover", 6, 1'b1, 3'b100, 2'd1, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
